// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO: idle low, start high, 8 data LSB first, stop low.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int DIV   = 8,
  parameter int DEPTH = 4
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       valid,
  output logic       ready,
  output logic       out,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        out_q, out_d;
  logic        busy_q, busy_d;
  logic        last;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign ready = !full;
  assign push  = valid && !full;
  assign head  = mem_q[rptr_q[AW-1:0]];
  assign last  = (div_q == DIV_LAST);
  assign out   = out_q;
  assign busy  = busy_q;

  // FIFO storage; contents need no reset since the pointers gate them
  always_ff @(posedge ref_clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= in;
  end

  // Frame sequencer: next state, bit timing, shift register and line level
  always_comb begin
    state_d = state_q;
    div_d   = last ? 8'd0 : div_q + 8'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    out_d   = out_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        div_d = 8'd0;
        out_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          out_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      START: begin
        if (last) begin
          state_d = DATA;
          out_d   = shift_q[0];
        end
      end
      DATA: begin
        if (last) begin
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            out_d   = par_q;
`else
            state_d = STOP;
            out_d   = 1'b0;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            out_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last) begin
          state_d = STOP;
          out_d   = 1'b0;
        end
      end
`endif
      STOP: begin
        if (last) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            out_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = IDLE;
            out_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = 8'd0;
        bit_d   = 3'd0;
        out_d   = 1'b0;
      end
    endcase
  end

  // Pointer updates and the busy flag derived from next-cycle state
  always_comb begin
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
    busy_d = (state_d != IDLE) || (wptr_d != rptr_d);
  end

  // All control state, synchronously reset
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
